// File: rtl/ram_pkg.sv
// ram_pkg: shared state type, depth helper and Hack word width for ram_param
package ram_pkg;
  localparam int HACK_WORD_W = 16;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/ram_word.sv
// ram_word: one storage word with async active-low reset, load enable and sync zero-write
module ram_word
  import ram_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             zero,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // zero-write from the clear engine takes priority over a data load
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (zero) q <= '0;
    else if (ld) q <= d;
endmodule

// File: rtl/ram_param.sv
// ram_param: parametrised word RAM with combinational read and bulk-clear engine; RAM_BYPASS_EN selects write-first read
module ram_param
  import ram_pkg::*;
#(
  parameter int WIDTH  = HACK_WORD_W,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              clear_done
);
  localparam int DEPTH = depth(ADDR_W);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic done_n, wr_en, last;
  logic [DEPTH-1:0] ld_sel, clr_sel;
  logic [WIDTH-1:0] q [DEPTH];
  assign busy  = state == CLEAR;
  assign last  = cnt == '1;
  assign wr_en = load && !busy && !clear;
  // one-hot decode of the host write address and the clear pointer
  always_comb
    for (int i = 0; i < DEPTH; i++) begin
      ld_sel[i]  = wr_en && addr == ADDR_W'(i);
      clr_sel[i] = busy && cnt == ADDR_W'(i);
    end
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    ram_word #(.WIDTH(WIDTH)) u_word (
      .clock  (clock),
      .reset_n(reset_n),
      .ld     (ld_sel[g]),
      .zero   (clr_sel[g]),
      .d      (in),
      .q      (q[g])
    );
  end
`ifdef RAM_BYPASS_EN
  assign out = wr_en ? in : q[addr];
`else
  assign out = q[addr];
`endif
  // clear sequencing: counter walks every word, exit pulses clear_done for one cycle
  always_comb begin
    state_n = busy ? (last ? IDLE : CLEAR) : (clear ? CLEAR : IDLE);
    cnt_n   = busy ? cnt + 1'b1 : '0;
    done_n  = busy && last;
  end
  // state, counter and completion pulse registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      clear_done <= done_n;
    end
endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: directed self-checking bench for ram_param (WIDTH=16, ADDR_W=3)
module tb_ram_param;
  logic clock = 1'b0, reset_n = 1'b0, load = 1'b0, clear = 1'b0;
  logic [15:0] in = '0, out;
  logic [2:0] addr = '0;
  logic busy, clear_done;
  int tests = 0, fails = 0;
`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ram_param #(.WIDTH(16), .ADDR_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .in(in), .addr(addr), .load(load),
    .clear(clear), .out(out), .busy(busy), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    load = 1'b1; addr = a; in = d;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      tests++;
      if (out !== 16'h0000) begin fails++; $display("FAIL reset_read[%0d] got %h exp 0000", a, out); end
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++;
    if (clear_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", clear_done); end
  endtask

  task automatic test_write_read;
    load = 1'b1; addr = 3'd3; in = 16'h1234;
    #1;
    tests++;
    if (out !== (BYP ? 16'h1234 : 16'h0000)) begin fails++; $display("FAIL pre_edge_read3 got %h exp %h", out, BYP ? 16'h1234 : 16'h0000); end
    tick();
    load = 1'b0;
    tests++;
    if (out !== 16'h1234) begin fails++; $display("FAIL post_edge_read3 got %h exp 1234", out); end
    wr(3'd7, 16'hBEEF);
    addr = 3'd3; #1;
    tests++;
    if (out !== 16'h1234) begin fails++; $display("FAIL read3 got %h exp 1234", out); end
    addr = 3'd7; #1;
    tests++;
    if (out !== 16'hBEEF) begin fails++; $display("FAIL read7 got %h exp BEEF", out); end
    addr = 3'd0; #1;
    tests++;
    if (out !== 16'h0000) begin fails++; $display("FAIL read0 got %h exp 0000", out); end
  endtask

  task automatic test_clear;
    int n;
    bit done_early;
    for (int a = 0; a < 8; a++) wr(3'(a), 16'hFFFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    done_early = 0;
    while (busy && n < 20) begin
      if (n == 2) begin load = 1'b1; addr = 3'd2; in = 16'hAAAA; end
      if (n == 3) load = 1'b0;
      if (n == 5) begin
        addr = 3'd0; #1;
        tests++;
        if (out !== 16'h0000) begin fails++; $display("FAIL mid_clear_read0 got %h exp 0000", out); end
        addr = 3'd6; #1;
        tests++;
        if (out !== 16'hFFFF) begin fails++; $display("FAIL mid_clear_read6 got %h exp FFFF", out); end
      end
      if (clear_done) done_early = 1;
      n++;
      tick();
    end
    load = 1'b0;
    tests++;
    if (n !== 8) begin fails++; $display("FAIL clear_busy_cycles got %0d exp 8", n); end
    tests++;
    if (done_early) begin fails++; $display("FAIL done_during_busy got 1 exp 0"); end
    tests++;
    if (clear_done !== 1'b1) begin fails++; $display("FAIL clear_done_pulse got %b exp 1", clear_done); end
    tick();
    tests++;
    if (clear_done !== 1'b0) begin fails++; $display("FAIL clear_done_width got %b exp 0", clear_done); end
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a); #1;
      tests++;
      if (out !== 16'h0000) begin fails++; $display("FAIL post_clear_read[%0d] got %h exp 0000", a, out); end
    end
  endtask

  task automatic test_clear_load_conflict;
    int n;
    wr(3'd1, 16'h1111);
    clear = 1'b1; load = 1'b1; addr = 3'd1; in = 16'h5555;
    #1;
    tests++;
    if (out !== 16'h1111) begin fails++; $display("FAIL conflict_same_cycle_read got %h exp 1111", out); end
    tick();
    clear = 1'b0; load = 1'b0;
    tests++;
    if (out !== 16'h1111) begin fails++; $display("FAIL conflict_write_dropped got %h exp 1111", out); end
    n = 0;
    while (busy && n < 20) begin
      clear = n == 3;
      n++;
      tick();
    end
    clear = 1'b0;
    tests++;
    if (n !== 8) begin fails++; $display("FAIL reclear_busy_cycles got %0d exp 8", n); end
    tests++;
    if (clear_done !== 1'b1) begin fails++; $display("FAIL reclear_done got %b exp 1", clear_done); end
    addr = 3'd1; #1;
    tests++;
    if (out !== 16'h0000) begin fails++; $display("FAIL conflict_word1 got %h exp 0000", out); end
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reclear_restarted got busy %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_clear;
    bit saw_done;
    for (int a = 5; a < 8; a++) wr(3'(a), 16'h00FF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (4) tick();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_clear_busy got %b exp 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
    for (int a = 5; a < 8; a++) begin
      addr = 3'(a); #1;
      tests++;
      if (out !== 16'h0000) begin fails++; $display("FAIL abort_read[%0d] got %h exp 0000", a, out); end
    end
    tick();
    reset_n = 1'b1;
    saw_done = 0;
    repeat (10) begin
      tick();
      if (clear_done || busy) saw_done = 1;
    end
    tests++;
    if (saw_done) begin fails++; $display("FAIL abort_no_done got pulse exp none"); end
  endtask

  task automatic test_bypass;
    load = 1'b1; addr = 3'd4; in = 16'h0F0F;
    #1;
    tests++;
    if (out !== (BYP ? 16'h0F0F : 16'h0000)) begin fails++; $display("FAIL bypass_read4 got %h exp %h", out, BYP ? 16'h0F0F : 16'h0000); end
    tick();
    load = 1'b0;
    tests++;
    if (out !== 16'h0F0F) begin fails++; $display("FAIL bypass_stored4 got %h exp 0F0F", out); end
    in = 16'h1234; #1;
    tests++;
    if (out !== 16'h0F0F) begin fails++; $display("FAIL noload_read4 got %h exp 0F0F", out); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear();
    test_clear_load_conflict();
    test_reset_mid_clear();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
